// File: rtl/regfile_writeback_if.sv
// Write-back bundle between the issue/execute side and the write-back arbiter.
//
// Handshake semantics (port B only): a transfer happens on every rising clock
// edge where b_valid_i and b_ready_o are both 1. b_ready_o depends only on
// registered state, never on b_valid_i. Once b_valid_i is raised, the source
// holds b_sel_i/b_data_i stable until the transfer edge. Port A has no ready.
// Instead, the source must keep a_valid_i low while a_stall_o is 1. Any A
// request made during a stall is ignored.
//
// Signals:
//   a_valid_i/a_sel_i/a_data_i             port A request (ALU result)
//   b_valid_i/b_ready_o/b_sel_i/b_data_i   port B handshake (long-latency results)
//   a_stall_o                              port A back-pressure
//   pending_o                              per-register queued-write bitmap
//   wb_en_o/wb_sel_o/wb_data_o             register file write port
// Modports: master = producer / register-file side, slave = arbiter.
interface regfile_writeback_if #(
  parameter int NREGS = 36
);
  logic             a_valid_i;
  logic [5:0]       a_sel_i;
  logic [31:0]      a_data_i;
  logic             b_valid_i;
  logic             b_ready_o;
  logic [5:0]       b_sel_i;
  logic [31:0]      b_data_i;
  logic             a_stall_o;
  logic [NREGS-1:0] pending_o;
  logic             wb_en_o;
  logic [5:0]       wb_sel_o;
  logic [31:0]      wb_data_o;

  modport master (
    output a_valid_i, a_sel_i, a_data_i, b_valid_i, b_sel_i, b_data_i,
    input  b_ready_o, a_stall_o, pending_o, wb_en_o, wb_sel_o, wb_data_o
  );

  modport slave (
    input  a_valid_i, a_sel_i, a_data_i, b_valid_i, b_sel_i, b_data_i,
    output b_ready_o, a_stall_o, pending_o, wb_en_o, wb_sel_o, wb_data_o
  );
endinterface

// File: rtl/regfile_writeback.sv
// Write-back arbiter in front of the register file's single write port.
// Port A is the in-order ALU result and has the highest priority.
// Port B carries long-latency results through a DEPTH-entry FIFO.
// pending_o flags every register that has a write queued or sitting in the
// output register, so the issue stage can stall on hazards.
// A starvation counter raises a_stall_o for one cycle after B has lost
// STARVE_LIMIT consecutive cycles to A.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset_n_i  asynchronous active-low reset
//   bus        regfile_writeback_if.slave (A/B requests, stall, pending, wb)
module regfile_writeback #(
  parameter int DEPTH        = 4,
  parameter int NREGS        = 36,
  parameter int STARVE_LIMIT = 8
) (
  input logic                clk,
  input logic                reset_n_i,
  regfile_writeback_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  // FIFO storage has no reset. Entries are only meaningful between the pointers.
  logic [5:0]  sel_mem_q  [DEPTH];
  logic [31:0] data_mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] fill_cnt;
  logic [SW-1:0] starve_q, starve_d;
  logic          stall_q;
  logic          wb_en_q, wb_en_d;
  logic [5:0]    wb_sel_q, wb_sel_d;
  logic [31:0]   wb_data_q, wb_data_d;

  logic full, empty, a_win, pop, push;
  logic [AW-1:0]    offs;
  logic [NREGS-1:0] pending_c;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign fill_cnt = wr_ptr_q - rd_ptr_q;

  // A write to x0 from either port is dropped. It never blocks the other port.
  assign a_win = !stall_q && bus.a_valid_i && (bus.a_sel_i != 6'd0);
  assign pop   = !a_win && !empty;
  assign push  = bus.b_valid_i && !full && (bus.b_sel_i != 6'd0);

  always_comb begin
    wr_ptr_d  = wr_ptr_q + PW'(push);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    starve_d  = starve_q;
    wb_en_d   = 1'b0;
    wb_sel_d  = wb_sel_q;
    wb_data_d = wb_data_q;
    if (pop) begin
      starve_d = '0;
    end else if (!empty && a_win && (starve_q < SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + SW'(1);
    end
    if (a_win) begin
      wb_en_d   = 1'b1;
      wb_sel_d  = bus.a_sel_i;
      wb_data_d = bus.a_data_i;
    end else if (pop) begin
      wb_en_d   = 1'b1;
      wb_sel_d  = sel_mem_q[rd_ptr_q[AW-1:0]];
      wb_data_d = data_mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      starve_q  <= '0;
      stall_q   <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_sel_q  <= '0;
      wb_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      starve_q  <= starve_d;
      stall_q   <= (starve_d == SW'(STARVE_LIMIT));
      wb_en_q   <= wb_en_d;
      wb_sel_q  <= wb_sel_d;
      wb_data_q <= wb_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      sel_mem_q[wr_ptr_q[AW-1:0]]  <= bus.b_sel_i;
      data_mem_q[wr_ptr_q[AW-1:0]] <= bus.b_data_i;
    end
  end

  // An entry is live when its distance from the read pointer is below the
  // fill count. Duplicate writes to the same register simply OR together.
  always_comb begin
    pending_c = '0;
    offs      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = AW'(i) - rd_ptr_q[AW-1:0];
      if ({1'b0, offs} < fill_cnt) begin
        for (int r = 0; r < NREGS; r++) begin
          if (sel_mem_q[i] == 6'(r)) pending_c[r] = 1'b1;
        end
      end
    end
    if (wb_en_q) begin
      for (int r = 0; r < NREGS; r++) begin
        if (wb_sel_q == 6'(r)) pending_c[r] = 1'b1;
      end
    end
  end

  assign bus.b_ready_o = !full;
  assign bus.a_stall_o = stall_q;
  assign bus.pending_o = pending_c;
  assign bus.wb_en_o   = wb_en_q;
  assign bus.wb_sel_o  = wb_sel_q;
  assign bus.wb_data_o = wb_data_q;
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed + random bench for regfile_writeback.
// The reference model is a queue of {sel, data} entries plus the write-back
// priority rules.
module tb_regfile_writeback;
  localparam int DEPTH = 4;
  localparam int NREGS = 36;
  localparam int LIMIT = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_writeback_if #(.NREGS(NREGS)) bus ();

  regfile_writeback #(.DEPTH(DEPTH), .NREGS(NREGS), .STARVE_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [37:0] exp_q[$];  // {sel, data} of queued B writes, oldest first
  int          m_cnt;
  bit          m_stall;
  bit          m_en;
  logic [5:0]  m_sel;
  logic [31:0] m_data;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic model_reset();
    exp_q.delete();
    m_cnt = 0; m_stall = 0; m_en = 0; m_sel = '0; m_data = '0;
  endtask

  task automatic model_edge(input bit av, input logic [5:0] asel, input logic [31:0] adata,
                            input bit bv, input logic [5:0] bsel, input logic [31:0] bdata);
    bit a_ok, popped, acc;
    bit was_busy;
    was_busy = (exp_q.size() > 0);
    a_ok   = !m_stall && av && (asel != 0);
    popped = !a_ok && was_busy;
    acc    = bv && (exp_q.size() < DEPTH);
    if (a_ok) begin
      m_en = 1; m_sel = asel; m_data = adata;
    end else if (popped) begin
      m_en = 1; {m_sel, m_data} = exp_q[0];
    end else begin
      m_en = 0;
    end
    if (popped) m_cnt = 0;
    else if (was_busy && a_ok && m_cnt < LIMIT) m_cnt++;
    m_stall = (m_cnt == LIMIT);
    if (popped) void'(exp_q.pop_front());
    if (acc && bsel != 0) exp_q.push_back({bsel, bdata});
  endtask

  function automatic logic [NREGS-1:0] exp_pending();
    logic [NREGS-1:0] p;
    p = '0;
    foreach (exp_q[i]) if (exp_q[i][37:32] < NREGS) p[exp_q[i][37:32]] = 1'b1;
    if (m_en && m_sel < NREGS) p[m_sel] = 1'b1;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".wb_en"},   64'(bus.wb_en_o),   64'(m_en));
    chk({ctx, ".wb_sel"},  64'(bus.wb_sel_o),  64'(m_sel));
    chk({ctx, ".wb_data"}, 64'(bus.wb_data_o), 64'(m_data));
    chk({ctx, ".pending"}, 64'(bus.pending_o), 64'(exp_pending()));
    chk({ctx, ".b_ready"}, 64'(bus.b_ready_o), 64'(exp_q.size() < DEPTH));
    chk({ctx, ".a_stall"}, 64'(bus.a_stall_o), 64'(m_stall));
  endtask

  // ---------------- driver ----------------
  task automatic step(input string ctx,
                      input bit av, input logic [5:0] asel, input logic [31:0] adata,
                      input bit bv, input logic [5:0] bsel, input logic [31:0] bdata);
    bus.a_valid_i = av; bus.a_sel_i = asel; bus.a_data_i = adata;
    bus.b_valid_i = bv; bus.b_sel_i = bsel; bus.b_data_i = bdata;
    model_edge(av, asel, adata, bv, bsel, bdata);
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  task automatic idle(input string ctx, input int n);
    for (int i = 0; i < n; i++) step(ctx, 0, 0, 0, 0, 0, 0);
  endtask

  int stall_seen;

  initial begin
    bus.a_valid_i = 0; bus.a_sel_i = 0; bus.a_data_i = 0;
    bus.b_valid_i = 0; bus.b_sel_i = 0; bus.b_data_i = 0;
    model_reset();

    // Reset values
    @(posedge clk); @(posedge clk); #1;
    check_all("reset");
    rst_n = 1'b1;

    // A only: one-cycle latency, pending[5] for exactly one cycle
    step("a_only", 1, 6'd5, 32'h1234, 0, 0, 0);
    chk("a_only.pend5", 64'(bus.pending_o[5]), 64'd1);
    idle("a_only_after", 1);
    chk("a_only.pend5_clr", 64'(bus.pending_o[5]), 64'd0);

    // B fill: A keeps the port busy so the FIFO fills, fifth write is refused
    for (int i = 1; i <= 5; i++)
      step("b_fill", 1, 6'(20 + i), 32'hA000 + i, 1, 6'(i), 32'hB000 + i);
    chk("b_fill.ready_full", 64'(bus.b_ready_o), 64'd0);
    for (int i = 1; i <= 4; i++) begin
      step("b_drain", 0, 0, 0, 0, 0, 0);
      chk("b_drain.order", 64'(bus.wb_sel_o), 64'(i));
    end
    idle("b_drain_idle", 2);

    // Two-cycle minimum latency for B
    step("b_lat0", 0, 0, 0, 1, 6'd9, 32'h99);
    chk("b_lat.not_yet", 64'(bus.wb_en_o), 64'd0);
    step("b_lat1", 0, 0, 0, 0, 0, 0);
    chk("b_lat.out", 64'(bus.wb_en_o), 64'd1);
    idle("b_lat_idle", 1);

    // Writes to x0 on both ports are dropped
    for (int i = 0; i < 3; i++) begin
      step("sel0", 1, 6'd0, 32'hDEAD, 1, 6'd0, 32'hBEEF);
      chk("sel0.pending", 64'(bus.pending_o), 64'd0);
    end

    // Starvation: B holds one entry while A is valid every cycle
    stall_seen = 0;
    step("starve", 1, 6'd9, 32'h900, 1, 6'd3, 32'h333);
    for (int i = 0; i < 11; i++) begin
      step("starve", 1, 6'd9, 32'h901 + i, 0, 0, 0);
      if (bus.a_stall_o) stall_seen++;
    end
    chk("starve.stall_cycles", 64'(stall_seen), 64'd1);
    idle("starve_idle", 1);

    // Duplicate queued writes to x7
    step("dup7", 1, 6'd10, 32'h1, 1, 6'd7, 32'h71);
    step("dup7", 1, 6'd11, 32'h2, 1, 6'd7, 32'h72);
    for (int i = 0; i < 3; i++) begin
      step("dup7_drain", 0, 0, 0, 0, 0, 0);
      chk("dup7.pend7", 64'(bus.pending_o[7]), 64'(i < 2));
    end

    // Reset with three queued entries
    for (int i = 0; i < 3; i++)
      step("rst_fill", 1, 6'(20 + i), 32'hC0 + i, 1, 6'(11 + i), 32'hD0 + i);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_mid");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step("rst_after", 0, 0, 0, 0, 0, 0);
      chk("rst_after.wb_en", 64'(bus.wb_en_o), 64'd0);
    end

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      step("rand",
           ($urandom_range(0, 3) != 0), 6'($urandom_range(0, 15)), $urandom(),
           ($urandom_range(0, 1) != 0), 6'($urandom_range(0, 15)), $urandom());
    end
    idle("rand_drain", 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
